// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: active-low segment
// patterns (bit 7 = dp, bits 6..0 = g..a), dp bit index and scan phase.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h83;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h98;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int DP_BIT = 7;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// CPU-side / pin-side signal bundle of the scan controller.
// master = display register owner (drives value/load), slave = controller.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic                  lz_blank;
  logic                  pending;
  logic [7:0]            seg_out;
  logic [DIGITS-1:0]     an_out;

  modport master (
    output load, value, dp_mask, lz_blank,
    input  pending, seg_out, an_out
  );

  modport slave (
    input  load, value, dp_mask, lz_blank,
    output pending, seg_out, an_out
  );
endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// BCD to active-low 7-segment pattern; codes 10..15 render as blank.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  // Pattern lookup for one BCD code.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. A shadow register captures
// loads; the active register is refreshed only at the start of the idx 0
// slot so each frame shows one consistent value. Each slot opens with
// BLANK_CYC cycles of all anodes off to suppress ghosting.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  phase_e              phase_q, phase_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic                pending_q, pending_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                wrap_s;
  logic [DIGITS-1:0]   zero_above_s;
  logic [3:0]          sel_digit_s;
  logic                sel_dp_s;
  logic                lz_sup_s;
  logic [DIGITS-1:0]   an_sel_s;
  logic [3:0]          dec_code_s;
  logic [7:0]          dec_seg_s;

  // Slot counter, digit index, phase and shadow/active commit logic.
  always_comb begin
    wrap_s    = (cnt_q == CNT_W'(DIV - 1));
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap_s) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d < CNT_W'(BLANK_CYC)) begin
      phase_d = PH_BLANK;
    end else begin
      phase_d = PH_DRIVE;
    end
    // Commit takes the shadow as it was before any same-cycle load, so a
    // load landing on the commit edge stays pending for the next frame.
    if (wrap_s && (idx_q == IDX_W'(DIGITS - 1)) && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else begin
      active_d  = active_q;
    end
    if (bus.load) begin
      shadow_d  = bus.value;
      pending_d = 1'b1;
    end else begin
      shadow_d  = shadow_q;
    end
  end

  // Current digit selection plus leading-zero suppression.
  always_comb begin
    zero_above_s = {DIGITS{1'b0}};
    sel_digit_s  = 4'h0;
    sel_dp_s     = 1'b0;
    lz_sup_s     = 1'b0;
    an_sel_s     = {DIGITS{1'b1}};
    zero_above_s[DIGITS-1] = (active_q[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_above_s[i] = (active_q[4*i +: 4] == 4'h0) && zero_above_s[i+1];
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_digit_s = active_q[4*i +: 4];
        sel_dp_s    = bus.dp_mask[i];
        an_sel_s[i] = 1'b0;
        if (i != 0) begin
          lz_sup_s = bus.lz_blank && zero_above_s[i];
        end else begin
          lz_sup_s = 1'b0;
        end
      end else begin
        an_sel_s[i] = 1'b1;
      end
    end
    if (lz_sup_s) begin
      dec_code_s = 4'hF;
    end else begin
      dec_code_s = sel_digit_s;
    end
  end

  seg_decode u_decode (
    .code (dec_code_s),
    .seg  (dec_seg_s)
  );

  // Next pin values: blank during dead time, decoded digit otherwise.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = {DIGITS{1'b1}};
    if (phase_q == PH_DRIVE) begin
      seg_d         = dec_seg_s;
      seg_d[DP_BIT] = dec_seg_s[DP_BIT] & ~sel_dp_s;
      an_d          = an_sel_s;
    end else begin
      seg_d = SEG_BLANK;
      an_d  = {DIGITS{1'b1}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      phase_q   <= PH_BLANK;
      shadow_q  <= {(4*DIGITS){1'b0}};
      active_q  <= {(4*DIGITS){1'b0}};
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= {DIGITS{1'b1}};
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign bus.pending = pending_q;
  assign bus.seg_out = seg_q;
  assign bus.an_out  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=8, BLANK_CYC=2.
// Outputs are sampled on the falling edge; ecnt counts rising edges since
// reset release, so the output after edge e shows slot ((e-1)/8)%4 and is
// blank when (e-1)%8 < 2. Commit edges are e = 32, 64, 96, ...
module tb_seg_scan_ctrl;

  logic clk;
  logic rst;
  int   ecnt;
  int   checks;
  int   errors;

  seg_scan_ctrl_if #(.DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .DIGITS    (4),
    .DIV       (8),
    .BLANK_CYC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic go_to(input int e);
    while (ecnt < e) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
    chk({tag, "_an"}, {4'h0, bus.an_out}, {4'h0, an_exp});
    chk({tag, "_seg"}, bus.seg_out, seg_exp);
  endtask

  task automatic load_at(input int e, input logic [15:0] v);
    go_to(e - 1);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    ecnt         = 0;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.dp_mask  = 4'h0;
    bus.lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and power-up scan of value 0.
    chk_out("rst", 4'hF, 8'hFF);
    chk("rst_pend", {7'd0, bus.pending}, 8'h00);
    go_to(1);  chk_out("e1_blank", 4'hF, 8'hFF);
    go_to(2);  chk_out("e2_blank", 4'hF, 8'hFF);
    go_to(3);  chk_out("d0_first", 4'hE, 8'hC0);
    go_to(8);  chk_out("d0_last", 4'hE, 8'hC0);
    go_to(9);  chk_out("d1_blank", 4'hF, 8'hFF);
    go_to(11); chk_out("d1", 4'hD, 8'hC0);
    go_to(19); chk_out("d2", 4'hB, 8'hC0);
    go_to(27); chk_out("d3", 4'h7, 8'hC0);

    // Mid-frame load of 1234, commits on edge 32.
    load_at(28, 16'h1234);
    chk("pend_set", {7'd0, bus.pending}, 8'h01);
    go_to(31); chk("pend_hold", {7'd0, bus.pending}, 8'h01);
    go_to(32); chk("pend_clr", {7'd0, bus.pending}, 8'h00);
    chk_out("old_d3", 4'h7, 8'hC0);
    go_to(33); chk_out("new_blank", 4'hF, 8'hFF);
    go_to(35); chk_out("v1234_d0", 4'hE, 8'h99);
    go_to(43); chk_out("v1234_d1", 4'hD, 8'hB0);
    go_to(51); chk_out("v1234_d2", 4'hB, 8'hA4);
    go_to(59); chk_out("v1234_d3", 4'h7, 8'hF9);

    // Leading-zero suppression.
    bus.lz_blank = 1'b1;
    load_at(60, 16'h0007);
    go_to(67); chk_out("lz7_d0", 4'hE, 8'hF8);
    go_to(75); chk_out("lz7_d1", 4'hD, 8'hFF);
    go_to(83); chk_out("lz7_d2", 4'hB, 8'hFF);
    go_to(91); chk_out("lz7_d3", 4'h7, 8'hFF);
    load_at(92, 16'h0000);
    go_to(99);  chk_out("lz0_d0", 4'hE, 8'hC0);
    go_to(107); chk_out("lz0_d1", 4'hD, 8'hFF);

    // Decimal point on digit 2 only.
    bus.lz_blank = 1'b0;
    bus.dp_mask  = 4'b0100;
    load_at(108, 16'h5678);
    go_to(131); chk_out("dp_d0", 4'hE, 8'h80);
    go_to(139); chk_out("dp_d1", 4'hD, 8'hF8);
    go_to(145); chk_out("dp_blank", 4'hF, 8'hFF);
    go_to(147); chk_out("dp_d2", 4'hB, 8'h03);
    go_to(155); chk_out("dp_d3", 4'h7, 8'h92);

    // Load colliding with the commit edge.
    bus.dp_mask = 4'h0;
    load_at(156, 16'h1111);
    load_at(160, 16'h2222);
    chk("coll_pend", {7'd0, bus.pending}, 8'h01);
    go_to(163); chk_out("coll_d0", 4'hE, 8'hF9);
    go_to(171); chk_out("coll_d1", 4'hD, 8'hF9);
    go_to(191); chk("coll_pend2", {7'd0, bus.pending}, 8'h01);
    go_to(192); chk("coll_pend3", {7'd0, bus.pending}, 8'h00);
    go_to(195); chk_out("next_d0", 4'hE, 8'hA4);
    go_to(203); chk_out("next_d1", 4'hD, 8'hA4);

    // Reset during DRIVE of digit 2 with a load pending.
    load_at(205, 16'h3333);
    go_to(211); chk_out("pre_rst_d2", 4'hB, 8'hA4);
    chk("pre_rst_pend", {7'd0, bus.pending}, 8'h01);
    rst = 1'b1;
    #1;
    chk_out("async_rst", 4'hF, 8'hFF);
    chk("async_rst_pend", {7'd0, bus.pending}, 8'h00);
    @(negedge clk);
    rst  = 1'b0;
    ecnt = 0;
    go_to(2);  chk_out("rs_blank", 4'hF, 8'hFF);
    go_to(3);  chk_out("rs_d0", 4'hE, 8'hC0);
    go_to(11); chk_out("rs_d1", 4'hD, 8'hC0);
    go_to(32); chk("rs_pend", {7'd0, bus.pending}, 8'h00);
    go_to(35); chk_out("rs_d0_f2", 4'hE, 8'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
